// File: rtl/fft_stage_sequencer.sv
// Issue sequencer for an in-place radix-2 FFT: walks every butterfly stage by stage and
// waits for all write-backs of a stage before issuing the next one.
module fft_stage_sequencer #(
  parameter int N             = 32,
  parameter int stage_width   = $clog2($clog2(N)),
  parameter int pair_id_width = $clog2(N/2),
  parameter int cnt_width     = $clog2(N/2) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     en,
  input  logic                     d_valid,
  output logic [stage_width-1:0]   stage,
  output logic [pair_id_width-1:0] pair_id,
  output logic                     i_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  localparam logic [pair_id_width-1:0] LAST_PAIR  = pair_id_width'(N/2 - 1);
  localparam logic [stage_width-1:0]   LAST_STAGE = stage_width'($clog2(N) - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t               state;
  logic [cnt_width-1:0] outstanding;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      stage       <= '0;
      pair_id     <= '0;
      i_valid     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      outstanding <= '0;
    end else begin
      done <= 1'b0;

      // A butterfly presented this cycle and a write-back in the same cycle cancel out.
      if (i_valid && !d_valid) begin
        outstanding <= outstanding + cnt_width'(1);
      end else if (d_valid && !i_valid) begin
        if (outstanding == '0) error <= 1'b1;
        else                   outstanding <= outstanding - cnt_width'(1);
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_ISSUE;
            stage   <= '0;
            pair_id <= '0;
            i_valid <= en;
            busy    <= 1'b1;
          end
        end
        S_ISSUE: begin
          // pair_id only advances once the current pair has actually been presented.
          if (i_valid && pair_id == LAST_PAIR) begin
            state   <= S_DRAIN;
            i_valid <= 1'b0;
          end else begin
            if (i_valid) pair_id <= pair_id + pair_id_width'(1);
            i_valid <= en;
          end
        end
        S_DRAIN: begin
          if (outstanding == '0) begin
            if (stage == LAST_STAGE) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state   <= S_ISSUE;
              stage   <= stage + stage_width'(1);
              pair_id <= '0;
              i_valid <= 1'b0;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench: expected butterfly order is pushed per run; a monitor pops on every
// issue, models the compute block's write-backs and checks the drain rule and done.
module tb_fft_stage_sequencer;
  localparam int N   = 32;
  localparam int SW  = $clog2($clog2(N));
  localparam int PW  = $clog2(N/2);
  localparam int NP  = N/2;
  localparam int NST = $clog2(N);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          en = 1'b0;
  logic          d_valid = 1'b0;
  logic [SW-1:0] stage;
  logic [PW-1:0] pair_id;
  logic          i_valid, busy, done, error;

  fft_stage_sequencer #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .en(en), .d_valid(d_valid),
    .stage(stage), .pair_id(pair_id), .i_valid(i_valid), .busy(busy),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int exp_q[$];
  int ret_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int t0, issued, returned, done_cnt;
  int first_rel, st1_rel, st3_rel, done_rel, busy_at_done, slow_dv;
  int lat_min = 4, lat_max = 4, hold_extra = 0;
  int e_mon, r_mon;
  bit spur = 1'b0;
  bit mon_on = 1'b0;
  bit found;

  task automatic check(input string nm, input longint got, input longint want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  // Compute-block model: drives one write-back per scheduled return cycle.
  initial forever begin
    @(posedge clk);
    #2;
    d_valid = spur;
    if (ret_q.size() > 0 && ret_q[0] <= cyc) begin
      void'(ret_q.pop_front());
      d_valid = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      if (d_valid && !spur) returned++;
      if (i_valid) begin
        check("issue_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e_mon = exp_q.pop_front();
          check("issue_stage", stage, e_mon / NP);
          check("issue_pair", pair_id, e_mon % NP);
          if (e_mon % NP == 0) check("stage_drained_before_issue", issued - returned, 0);
        end
        issued++;
        if (first_rel < 0) first_rel = cyc - t0;
        if (stage == 1 && st1_rel < 0) st1_rel = cyc - t0;
        if (stage == 3 && st3_rel < 0) st3_rel = cyc - t0;
        r_mon = cyc + $urandom_range(lat_max, lat_min);
        if (stage == 2 && pair_id == NP-1) begin
          r_mon += hold_extra;
          slow_dv = r_mon - t0;
        end
        if (ret_q.size() > 0 && r_mon <= ret_q[$]) r_mon = ret_q[$] + 1;
        ret_q.push_back(r_mon);
      end
      if (done) begin
        done_cnt++;
        done_rel = cyc - t0;
        busy_at_done = busy;
        check("done_all_issued", exp_q.size(), 0);
        check("done_all_returned", issued - returned, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch();
    exp_q.delete();
    for (int s = 0; s < NST; s++)
      for (int p = 0; p < NP; p++) exp_q.push_back(s*NP + p);
    issued = 0; returned = 0; done_cnt = 0;
    first_rel = -1; st1_rel = -1; st3_rel = -1; done_rel = -1; slow_dv = -1;
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rand_en, input bit rand_start);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      if (rand_en)    en = ($urandom_range(3, 0) != 0);
      if (rand_start) start = busy & 1'($urandom_range(1, 0));
      tick();
      n++;
    end
    start = 1'b0;
    en = 1'b1;
    check("done_within_budget", done_cnt > 0, 1);
    repeat (4) tick();
    check("one_done_per_run", done_cnt, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_stage"}, stage, 0);
    check({tag, "_pair"}, pair_id, 0);
    check({tag, "_i_valid"}, i_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) tick();
    check_idle_outputs("reset");
    reset = 1'b1;
    en = 1'b1;
    mon_on = 1'b1;
    tick();

    // Nominal run, fixed write-back latency of 4.
    launch();
    wait_done(400, 1'b0, 1'b0);
    check("nom_first_issue", first_rel, 1);
    check("nom_stage1_start", st1_rel, 23);
    check("nom_done_cycle", done_rel, 110);
    check("nom_issue_count", issued, 80);
    check("nom_busy_at_done", busy_at_done, 0);
    check("nom_error", error, 0);

    // Issue stall: pair 4 held invalid for three cycles, then presented.
    launch();
    for (int k = 1; k <= 8; k++) begin
      en = !(k >= 4 && k <= 6);
      @(negedge clk);
      if (k >= 5) begin
        check("stall_pair", pair_id, 4);
        check("stall_valid", i_valid, k == 8);
      end
      tick();
    end
    wait_done(400, 1'b0, 1'b0);
    check("stall_issue_count", issued, 80);
    check("stall_done_cycle", done_rel, 113);

    // Last write-back of stage 2 held back 30 cycles.
    hold_extra = 30;
    launch();
    wait_done(500, 1'b0, 1'b0);
    hold_extra = 0;
    check("slow_dv_cycle", slow_dv, 94);
    check("slow_stage3_issue", st3_rel, slow_dv + 3);
    check("slow_done_cycle", done_rel, 140);

    // Spurious write-back while idle: sticky error, counter unharmed.
    spur = 1'b1;
    tick();
    spur = 1'b0;
    tick();
    check("spur_error_set", error, 1);
    launch();
    wait_done(400, 1'b0, 1'b0);
    check("spur_run_done_cycle", done_rel, 110);
    check("spur_error_sticky", error, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("spur_error_cleared", error, 0);

    // Reset mid-transform at stage 2, pair 9.
    launch();
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (i_valid && stage == 2 && pair_id == 9) found = 1'b1;
      else tick();
    end
    check("abort_point_reached", found, 1);
    #1;
    mon_on = 1'b0;
    ret_q.delete();
    exp_q.delete();
    reset = 1'b0;
    tick();
    check_idle_outputs("abort");
    reset = 1'b1;
    mon_on = 1'b1;
    launch();
    wait_done(400, 1'b0, 1'b0);
    check("abort_relaunch_first", first_rel, 1);
    check("abort_relaunch_done", done_rel, 110);

    // Random en, random latency, stray start pulses during the run.
    lat_min = 1;
    lat_max = 6;
    for (int r = 0; r < 3; r++) begin
      launch();
      wait_done(3000, 1'b1, 1'b1);
      check("rand_issue_count", issued, 80);
      check("rand_error", error, 0);
      check("rand_busy_after", busy, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
